mainfsm: RTL

//  Multicycle MIPS main control FSM. Sequences the shared datapath (memory, ALU, register file, PC)

---
 rtl/mainfsm.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mainfsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute for lw, sw,
// R-type, beq, addi and j, with optional memory wait-state handshake.
module mainfsm #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       memready,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_e state_q, state_d;
    logic   mem_rdy;
    logic   pcwrite;
    logic   branch;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        mem_rdy  = MEM_HANDSHAKE ? memready : 1'b1;
        state_d  = S_FETCH;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        pcsrc    = 2'b00;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        aluop    = 2'b00;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        illegal  = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrcb = 2'b01;
                irwrite = mem_rdy;
                pcwrite = mem_rdy;
                state_d = mem_rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (op == OP_LW)      state_d = S_MEMRD;
                else if (op == OP_SW) state_d = S_MEMWR;
                else                  state_d = S_FETCH;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = mem_rdy ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                state_d  = mem_rdy ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        pcen  = pcwrite | (branch & zero);
        state = state_q;

        // Reset forces every output low combinationally so nothing leaks in the reset cycle
        if (reset) begin
            memwrite = 1'b0;
            iord     = 1'b0;
            irwrite  = 1'b0;
            pcen     = 1'b0;
            pcsrc    = 2'b00;
            alusrca  = 1'b0;
            alusrcb  = 2'b00;
            aluop    = 2'b00;
            regdst   = 1'b0;
            memtoreg = 1'b0;
            regwrite = 1'b0;
            illegal  = 1'b0;
            state    = '0;
        end
    end

endmodule
